seven_seg_capture: RTL

// - Reverse path of the cathode encoder: monitors a multiplexed, active-low 4-digit
//   7-segment bus (anodes + cathodes) and reconstructs the nibble shown at each position.
// - Used as an on-board loopback checker and self-test monitor beside the display driver.
// - Qualifies each anode slot with a stability counter, decodes the pattern, flags

---
 rtl/seven_seg_capture.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// Monitors a multiplexed active-low 4-digit 7-segment bus and reconstructs the nibble shown at each position.
// Optional per-position refresh timeout is enabled by defining SEG_CAPTURE_TIMEOUT_EN.
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  illegal,
    output logic        update
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0] an_held_q, an_held_d;
    logic [6:0] seg_held_q, seg_held_d;
    logic       mode_prev_q, mode_prev_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0] valid_q, valid_d;
    logic [3:0] illegal_q, illegal_d;
    logic       update_q, update_d;
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    logic       one_low;
    logic       same_pair;
    logic       mode_changed;
    logic       capture;
    logic [1:0] pos;
    logic [6:0] pattern;
    logic [4:0] decoded;

`ifdef SEG_CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [3:0][TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]           to_act_q, to_act_d;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    // Returns {legal, nibble}; decimal mode rejects A-F and adds the minus glyph.
    function automatic logic [4:0] decode_glyph(input logic dec_mode, input logic [6:0] p);
        logic       legal;
        logic [3:0] nib;
        legal = 1'b1;
        nib   = 4'h0;
        case (p)
            7'h7E: nib = 4'h0;
            7'h30: nib = 4'h1;
            7'h6D: nib = 4'h2;
            7'h79: nib = 4'h3;
            7'h33: nib = 4'h4;
            7'h5B: nib = 4'h5;
            7'h5F: nib = 4'h6;
            7'h70: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h7B: nib = 4'h9;
            7'h77: begin nib = 4'hA; legal = !dec_mode; end
            7'h1F: begin nib = 4'hB; legal = !dec_mode; end
            7'h4E: begin nib = 4'hC; legal = !dec_mode; end
            7'h3D: begin nib = 4'hD; legal = !dec_mode; end
            7'h4F: begin nib = 4'hE; legal = !dec_mode; end
            7'h47: begin nib = 4'hF; legal = !dec_mode; end
            7'h01: begin nib = 4'hF; legal = dec_mode; end
            default: legal = 1'b0;
        endcase
        return {legal, nib};
    endfunction

    // Reset asserts asynchronously but is released to the core only after two clean edges.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_comb begin
        one_low      = $onehot(~an);
        same_pair    = (an == an_held_q) && (seg == seg_held_q);
        mode_changed = (mode != mode_prev_q);
        pattern      = ~seg;
        decoded      = decode_glyph(mode, pattern);
        pos          = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                pos = 2'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        an_held_d   = an_held_q;
        seg_held_d  = seg_held_q;
        mode_prev_d = mode;
        digits_d    = digits_q;
        valid_d     = valid_q;
        illegal_d   = illegal_q;
        capture     = 1'b0;
`ifdef SEG_CAPTURE_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_act_d = to_act_q;
        for (int i = 0; i < 4; i++) begin
            if (to_act_q[i]) begin
                if (to_cnt_q[i] + TO_W'(1) == TO_W'(TIMEOUT_CYCLES)) begin
                    to_act_d[i]         = 1'b0;
                    to_cnt_d[i]         = '0;
                    valid_d[i]          = 1'b0;
                    illegal_d[i]        = 1'b0;
                    digits_d[4*i +: 4]  = 4'h0;
                end else begin
                    to_cnt_d[i] = to_cnt_q[i] + TO_W'(1);
                end
            end
        end
`endif

        if (mode_changed) begin
            state_d   = IDLE;
            count_d   = '0;
            valid_d   = 4'b0000;
            illegal_d = 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (one_low) begin
                        state_d    = TRACK;
                        an_held_d  = an;
                        seg_held_d = seg;
                        count_d    = CNT_W'(1);
                    end else begin
                        count_d = '0;
                    end
                end
                TRACK: begin
                    if (!one_low) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (same_pair) begin
                        if (count_q + CNT_W'(1) == CNT_W'(STABLE_CYCLES)) begin
                            capture = 1'b1;
                            state_d = HOLD;
                        end
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        an_held_d  = an;
                        seg_held_d = seg;
                        count_d    = CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!same_pair) begin
                        if (one_low) begin
                            state_d    = TRACK;
                            an_held_d  = an;
                            seg_held_d = seg;
                            count_d    = CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        // Illegal glyphs keep the last good nibble so the monitor can still report it.
        if (capture) begin
            if (decoded[4]) begin
                digits_d[{pos, 2'b00} +: 4] = decoded[3:0];
                valid_d[pos]                = 1'b1;
                illegal_d[pos]              = 1'b0;
            end else if (pattern == 7'h00) begin
                digits_d[{pos, 2'b00} +: 4] = 4'h0;
                valid_d[pos]                = 1'b0;
                illegal_d[pos]              = 1'b0;
            end else begin
                valid_d[pos]   = 1'b0;
                illegal_d[pos] = 1'b1;
            end
        end

`ifdef SEG_CAPTURE_TIMEOUT_EN
        if (mode_changed) begin
            to_act_d = 4'b0000;
            to_cnt_d = '0;
        end else if (capture) begin
            to_act_d[pos] = 1'b1;
            to_cnt_d[pos] = '0;
        end
`endif

        update_d = (digits_d != digits_q) || (valid_d != valid_q) || (illegal_d != illegal_q);
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            an_held_q   <= 4'hF;
            seg_held_q  <= 7'h7F;
            mode_prev_q <= 1'b0;
            digits_q    <= 16'h0000;
            valid_q     <= 4'b0000;
            illegal_q   <= 4'b0000;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            an_held_q   <= an_held_d;
            seg_held_q  <= seg_held_d;
            mode_prev_q <= mode_prev_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            illegal_q   <= illegal_d;
            update_q    <= update_d;
        end
    end

`ifdef SEG_CAPTURE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            to_cnt_q <= '0;
            to_act_q <= 4'b0000;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_act_q <= to_act_d;
        end
    end
`endif

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign illegal     = illegal_q;
    assign update      = update_q;

endmodule
